prio_arbiter: RTL and testbench

Parametrised, registered priority arbiter: next generation of the team's 16x4 combinational priority encoder. Takes a WIDTH-bit request vector, selects one winner by fixed priority (highest index wins) or by rotating round-robin priority, and presents the winner as a registered index plus one-hot grant behind a valid/ready handshake. Sits between request sources (interrupt lines, FIFO-not-empty flags) and a single shared consumer that accepts one grant at a time.

---
 rtl/arb_pkg.sv | 12 +
 rtl/prio_enc_n.sv | 26 ++
 rtl/prio_arbiter.sv | 128 ++++++++++++
 tb/tb_prio_arbiter.sv | 136 +++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types for the registered priority arbiter.
// Only the arbitration state encoding lives here.
// Imported by the arbiter top.
package arb_pkg;

  // IDLE: no grant held. HOLD: grant presented, waiting for the consumer.
  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_HOLD = 1'b1
  } arb_state_e;

endpackage : arb_pkg

// File: rtl/prio_enc_n.sv
// Combinational N-way priority encoder: highest set index wins.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller registers and holds the result.
module prio_enc_n #(
  parameter  int WIDTH = 16,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Ascending scan: a later (higher) set bit overrides earlier ones, so the
  // highest set index is left in idx. idx is 0 when nothing is set.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (vec[i]) begin
        idx = IDX_W'(i);
        any = 1'b1;
      end
    end
  end

endmodule : prio_enc_n

// File: rtl/prio_arbiter.sv
// Registered fixed / round-robin priority arbiter with valid-ready grant.
// Latency: request to gnt_valid in 1 cycle; one grant per cycle when ready.
// Backpressure: a presented grant is held stable until gnt_valid & gnt_ready.
module prio_arbiter
  import arb_pkg::*;
#(
  parameter  int WIDTH = 16,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] req,
  input  logic             mode_rr,
  output logic             gnt_valid,
  input  logic             gnt_ready,
  output logic [IDX_W-1:0] gnt_idx,
  output logic [WIDTH-1:0] gnt_onehot
);

  arb_state_e       state;
  logic [IDX_W-1:0] ptr;

  logic             handshake;
  logic [WIDTH-1:0] cand;
  logic [WIDTH-1:0] ptr_mask;
  logic [IDX_W-1:0] low_idx;
  logic             low_any;
  logic [IDX_W-1:0] all_idx;
  logic             all_any;
  logic [IDX_W-1:0] win_idx;
  logic [WIDTH-1:0] win_onehot;
  logic [IDX_W-1:0] ptr_next;

  // Outputs are registered, so a handshake is only possible in HOLD.
  assign handshake = gnt_valid & gnt_ready;

  // Candidates: the source just accepted is dropped for this cycle so its
  // still-high request level cannot win twice back-to-back.
  always_comb begin
    cand = req;
    if (state == ARB_HOLD && handshake) begin
      cand = req & ~gnt_onehot;
    end
  end

  // Indices at or below ptr form the top of the rotating priority order.
  always_comb begin
    ptr_mask = '0;
    for (int i = 0; i < WIDTH; i++) begin
      ptr_mask[i] = (i <= int'(ptr));
    end
  end

  prio_enc_n #(.WIDTH(WIDTH)) u_enc_low (
    .vec (cand & ptr_mask),
    .idx (low_idx),
    .any (low_any)
  );

  prio_enc_n #(.WIDTH(WIDTH)) u_enc_all (
    .vec (cand),
    .idx (all_idx),
    .any (all_any)
  );

  // Round-robin prefers the highest candidate at or below ptr; if none, the
  // order wraps to WIDTH-1 downwards, which the unmasked encoder gives.
  always_comb begin
    win_idx = all_idx;
    if (mode_rr && low_any) begin
      win_idx = low_idx;
    end
    win_onehot = {{(WIDTH-1){1'b0}}, 1'b1} << win_idx;
  end

  // Accepted source becomes lowest priority; explicit wrap keeps this correct
  // for WIDTH values that are not a power of two.
  always_comb begin
    if (gnt_idx == '0) begin
      ptr_next = IDX_W'(WIDTH - 1);
    end else begin
      ptr_next = gnt_idx - IDX_W'(1);
    end
  end

  // State, rotation pointer and grant registers; reset wins over everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ARB_IDLE;
      ptr        <= IDX_W'(WIDTH - 1);
      gnt_valid  <= 1'b0;
      gnt_idx    <= '0;
      gnt_onehot <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (all_any) begin
            state      <= ARB_HOLD;
            gnt_valid  <= 1'b1;
            gnt_idx    <= win_idx;
            gnt_onehot <= win_onehot;
          end
        end
        ARB_HOLD: begin
          if (handshake) begin
            if (mode_rr) begin
              ptr <= ptr_next;
            end
            if (all_any) begin
              gnt_idx    <= win_idx;
              gnt_onehot <= win_onehot;
            end else begin
              state      <= ARB_IDLE;
              gnt_valid  <= 1'b0;
              gnt_onehot <= '0;
            end
          end
        end
        default: begin
          state      <= ARB_IDLE;
          gnt_valid  <= 1'b0;
          gnt_onehot <= '0;
        end
      endcase
    end
  end

endmodule : prio_arbiter

// File: tb/tb_prio_arbiter.sv
// Directed-vector bench for prio_arbiter (WIDTH = 16).
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
// Each check compares against hand-computed constants.
module tb_prio_arbiter;

  logic        clk;
  logic        rst_n;
  logic [15:0] req;
  logic        mode_rr;
  logic        gnt_valid;
  logic        gnt_ready;
  logic [3:0]  gnt_idx;
  logic [15:0] gnt_onehot;

  int n_chk;
  int n_pass;

  prio_arbiter #(.WIDTH(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .mode_rr    (mode_rr),
    .gnt_valid  (gnt_valid),
    .gnt_ready  (gnt_ready),
    .gnt_idx    (gnt_idx),
    .gnt_onehot (gnt_onehot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check the whole registered grant in one go.
  task automatic chk_gnt(input string tag, input logic v, input logic [3:0] idx, input logic [15:0] oh);
    chk({tag, ".valid"}, 32'(gnt_valid), 32'(v));
    chk({tag, ".idx"}, 32'(gnt_idx), 32'(idx));
    chk({tag, ".onehot"}, 32'(gnt_onehot), 32'(oh));
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;

    // Reset held 3 cycles with every request up and the consumer ready.
    rst_n = 1'b0; req = 16'hFFFF; gnt_ready = 1'b1; mode_rr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_gnt("reset", 1'b0, 4'd0, 16'h0000);
    end
    rst_n = 1'b1; req = 16'h0000; gnt_ready = 1'b0;
    tick();
    chk("idle_no_req.valid", 32'(gnt_valid), 32'd0);

    // Fixed priority: highest index wins, held until the handshake.
    req = 16'h0124;
    tick();
    chk_gnt("fixed_first", 1'b1, 4'd8, 16'h0100);
    req = 16'h0000;
    tick();
    chk_gnt("fixed_hold", 1'b1, 4'd8, 16'h0100);
    req = 16'h0024; gnt_ready = 1'b1;
    tick();
    chk_gnt("fixed_next", 1'b1, 4'd5, 16'h0020);
    req = 16'h0000;
    tick();
    chk_gnt("fixed_drain", 1'b0, 4'd5, 16'h0000);

    // Stale level of the accepted source is masked for one cycle.
    req = 16'h0010;
    tick(); chk_gnt("mask_g1", 1'b1, 4'd4, 16'h0010);
    tick(); chk_gnt("mask_gap", 1'b0, 4'd4, 16'h0000);
    tick(); chk_gnt("mask_g2", 1'b1, 4'd4, 16'h0010);
    req = 16'h0000;
    tick(); chk("mask_end.valid", 32'(gnt_valid), 32'd0);
    tick(); chk("idle_stays.valid", 32'(gnt_valid), 32'd0);

    // Round-robin fairness between sources 15 and 0 (ptr starts at 15).
    mode_rr = 1'b1; req = 16'h8001;
    tick(); chk_gnt("rr_0", 1'b1, 4'd15, 16'h8000);
    tick(); chk_gnt("rr_1", 1'b1, 4'd0,  16'h0001);
    tick(); chk_gnt("rr_2", 1'b1, 4'd15, 16'h8000);
    tick(); chk_gnt("rr_3", 1'b1, 4'd0,  16'h0001);
    // Accepting idx 0 wraps ptr to 15.
    req = 16'h0000;
    tick(); chk("rr_drain.valid", 32'(gnt_valid), 32'd0);
    gnt_ready = 1'b0; req = 16'h8001;
    tick(); chk_gnt("rr_wrap", 1'b1, 4'd15, 16'h8000);
    // Fixed-mode handshake leaves ptr at 15.
    mode_rr = 1'b0; gnt_ready = 1'b1; req = 16'h0000;
    tick(); chk("fixed_hs_drain.valid", 32'(gnt_valid), 32'd0);

    // No pre-emption by a higher-priority late arrival.
    gnt_ready = 1'b0; req = 16'h0004;
    tick(); chk_gnt("nopre_0", 1'b1, 4'd2, 16'h0004);
    req = 16'h8004;
    tick(); chk_gnt("nopre_1", 1'b1, 4'd2, 16'h0004);
    tick(); chk_gnt("nopre_2", 1'b1, 4'd2, 16'h0004);
    gnt_ready = 1'b1;
    tick(); chk_gnt("nopre_hs", 1'b1, 4'd15, 16'h8000);
    req = 16'h0000;
    tick(); chk("nopre_drain.valid", 32'(gnt_valid), 32'd0);

    // Reset with a handshake pending must not move ptr (15, not 8).
    mode_rr = 1'b1; gnt_ready = 1'b0; req = 16'h0200;
    tick(); chk_gnt("rst_mid_pre", 1'b1, 4'd9, 16'h0200);
    rst_n = 1'b0; gnt_ready = 1'b1;
    tick(); chk_gnt("rst_mid", 1'b0, 4'd0, 16'h0000);
    rst_n = 1'b1; gnt_ready = 1'b0; req = 16'h0300;
    // ptr 15 picks 9; a ptr of 8 would have picked 8.
    tick(); chk_gnt("rst_ptr", 1'b1, 4'd9, 16'h0200);
    gnt_ready = 1'b1;
    // Accept 9 -> ptr 8; 9 masked so 8 wins.
    tick(); chk_gnt("rr_after_rst_0", 1'b1, 4'd8, 16'h0100);
    // Accept 8 -> ptr 7; 8 masked, nothing at or below 7, wrap gives 9.
    tick(); chk_gnt("rr_after_rst_1", 1'b1, 4'd9, 16'h0200);
    req = 16'h0000;
    tick(); chk("final_drain.valid", 32'(gnt_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_prio_arbiter
